// File: rtl/pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_hazard_ctrl
//  Description : Central pipeline controller for the SIMD core. Combines the
//                control word held in ID/EX with the source-register info of
//                the instruction in decode. From these it produces the stall,
//                flush and PC-select signals for every pipeline register. It
//                also sequences multi-beat vector memory transfers
//                (lopix/svpix), holding the pipeline frozen until every beat
//                has been accepted.
//  Ports       :
//    clk, rst (async, active-low)      clock / reset
//    id_valid, id_src_a/b, id_use_a/b,
//    id_src_vec                        decode-stage source info
//    ex_valid, ex_pc_write_en, ex_zero,
//    ex_reg_write_sc/vec, ex_reg_to_write,
//    ex_write_reg_from, ex_vec_mem     ID/EX control word
//    mem_ready                         memory accepts current vector beat
//    pc_stall, ifid_stall, ifid_flush,
//    idex_flush, exmem_stall, pc_sel   pipeline control
//    mem_req, beat_idx, vmem_busy      vector beat sequencing
//    stall_cycles                      saturating pc_stall cycle counter
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_hazard_ctrl #(
   parameter int VEC_BEATS = 4,
   parameter int CNT_W     = 16
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         id_valid,
   input  logic [3:0]                   id_src_a,
   input  logic [3:0]                   id_src_b,
   input  logic                         id_use_a,
   input  logic                         id_use_b,
   input  logic                         id_src_vec,
   input  logic                         ex_valid,
   input  logic [2:0]                   ex_pc_write_en,
   input  logic                         ex_zero,
   input  logic                         ex_reg_write_sc,
   input  logic                         ex_reg_write_vec,
   input  logic [3:0]                   ex_reg_to_write,
   input  logic [1:0]                   ex_write_reg_from,
   input  logic                         ex_vec_mem,
   input  logic                         mem_ready,
   output logic                         pc_stall,
   output logic                         ifid_stall,
   output logic                         ifid_flush,
   output logic                         idex_flush,
   output logic                         exmem_stall,
   output logic                         pc_sel,
   output logic                         mem_req,
   output logic [$clog2(VEC_BEATS)-1:0] beat_idx,
   output logic                         vmem_busy,
   output logic [CNT_W-1:0]             stall_cycles
);

   localparam int                    c_BEAT_W    = $clog2(VEC_BEATS);
   localparam logic [c_BEAT_W-1:0]   c_LAST_BEAT = c_BEAT_W'(VEC_BEATS - 1);
   localparam logic [CNT_W-1:0]      c_CNT_MAX   = '1;

   typedef enum logic [0:0] {
      c_ST_RUN  = 1'b0,
      c_ST_VMEM = 1'b1
   } state_t;

   state_t              r_state, w_nextState;
   logic [c_BEAT_W-1:0] r_beatIdx, w_nextBeat;
   logic                r_done, w_nextDone;
   logic [CNT_W-1:0]    r_stallCycles;

   logic w_take, w_ldUse, w_vstart, w_classMatch, w_srcHit;
   logic w_pcStall, w_ifidStall, w_ifidFlush, w_idexFlush;
   logic w_exmemStall, w_pcSel, w_memReq;

   // ------------------------------------------------------------------------
   // Hazard detection on the current ID/EX and decode contents
   // ------------------------------------------------------------------------
   assign w_take = ex_valid & (ex_pc_write_en[2]
                             | (ex_pc_write_en[1] & ex_zero)
                             | (ex_pc_write_en[0] & ~ex_zero));

   // A load only conflicts with readers of the same register file.
   assign w_classMatch = (ex_reg_write_sc & ~id_src_vec) | (ex_reg_write_vec & id_src_vec);
   assign w_srcHit     = (id_use_a & (id_src_a == ex_reg_to_write))
                       | (id_use_b & (id_src_b == ex_reg_to_write));
   assign w_ldUse      = ex_valid & ~ex_vec_mem & (ex_write_reg_from == 2'd0)
                       & w_classMatch & id_valid & w_srcHit;

   assign w_vstart = ex_valid & ex_vec_mem;

   // ------------------------------------------------------------------------
   // Next-state / output logic
   // ------------------------------------------------------------------------
   always_comb begin
      w_nextState  = r_state;
      w_nextBeat   = r_beatIdx;
      w_nextDone   = r_done;
      w_pcStall    = 1'b0;
      w_ifidStall  = 1'b0;
      w_ifidFlush  = 1'b0;
      w_idexFlush  = 1'b0;
      w_exmemStall = 1'b0;
      w_pcSel      = 1'b0;
      w_memReq     = 1'b0;

      case (r_state)
         c_ST_RUN: begin
            // r_done masks the vector op that just finished and is still
            // sitting in ID/EX for its one release cycle.
            if (w_vstart && !r_done) begin
               w_pcStall    = 1'b1;
               w_ifidStall  = 1'b1;
               w_exmemStall = 1'b1;
               w_nextState  = c_ST_VMEM;
               w_nextBeat   = '0;
            end else if (w_take && !w_vstart) begin
               // A vector op presented together with a branch never branches.
               w_pcSel     = 1'b1;
               w_ifidFlush = 1'b1;
               w_idexFlush = 1'b1;
            end else if (w_ldUse) begin
               w_pcStall   = 1'b1;
               w_ifidStall = 1'b1;
               w_idexFlush = 1'b1;
            end
            if (!w_pcStall) begin
               w_nextDone = 1'b0;
            end
         end

         c_ST_VMEM: begin
            w_pcStall    = 1'b1;
            w_ifidStall  = 1'b1;
            w_exmemStall = 1'b1;
            w_memReq     = 1'b1;
            if (mem_ready) begin
               if (r_beatIdx == c_LAST_BEAT) begin
                  w_nextState = c_ST_RUN;
                  w_nextBeat  = '0;
                  w_nextDone  = 1'b1;
               end else begin
                  w_nextBeat = r_beatIdx + c_BEAT_W'(1);
               end
            end
         end

         default: begin
            w_nextState = c_ST_RUN;
            w_nextBeat  = '0;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // State, beat counter and performance counter
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state       <= c_ST_RUN;
         r_beatIdx     <= '0;
         r_done        <= 1'b0;
         r_stallCycles <= '0;
      end else begin
         r_state   <= w_nextState;
         r_beatIdx <= w_nextBeat;
         r_done    <= w_nextDone;
         if (w_pcStall && (r_stallCycles != c_CNT_MAX)) begin
            r_stallCycles <= r_stallCycles + CNT_W'(1);
         end
      end
   end

   // The control outputs are combinational from the inputs, so they are
   // forced low while reset is held rather than relying on the state reset.
   assign pc_stall     = rst & w_pcStall;
   assign ifid_stall   = rst & w_ifidStall;
   assign ifid_flush   = rst & w_ifidFlush;
   assign idex_flush   = rst & w_idexFlush;
   assign exmem_stall  = rst & w_exmemStall;
   assign pc_sel       = rst & w_pcSel;
   assign mem_req      = rst & w_memReq;
   assign vmem_busy    = rst & (r_state == c_ST_VMEM);
   assign beat_idx     = r_beatIdx;
   assign stall_cycles = r_stallCycles;

endmodule
`default_nettype wire

// File: tb/tb_pipeline_hazard_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_hazard_ctrl
//  Description : Self-checking bench for pipeline_hazard_ctrl. Directed
//                scenario tasks plus a randomized run against a behavioural
//                model. A second instance with CNT_W=4 exercises counter
//                saturation.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_hazard_ctrl;

   localparam int c_VB = 4;
   localparam int c_BW = $clog2(c_VB);

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       id_valid, id_src_vec, id_use_a, id_use_b;
   logic [3:0] id_src_a, id_src_b;
   logic       ex_valid, ex_zero, ex_reg_write_sc, ex_reg_write_vec, ex_vec_mem;
   logic [2:0] ex_pc_write_en;
   logic [3:0] ex_reg_to_write;
   logic [1:0] ex_write_reg_from;
   logic       mem_ready;

   logic            pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_stall;
   logic            pc_sel, mem_req, vmem_busy;
   logic [c_BW-1:0] beat_idx;
   logic [15:0]     stall_cycles;

   logic            pc_stall4, ifid_stall4, ifid_flush4, idex_flush4, exmem_stall4;
   logic            pc_sel4, mem_req4, vmem_busy4;
   logic [c_BW-1:0] beat_idx4;
   logic [3:0]      stall_cycles4;

   int nAssert = 0;
   int nFail   = 0;

   always #5 clk = ~clk;

   pipeline_hazard_ctrl #(.VEC_BEATS(c_VB), .CNT_W(16)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_src_a(id_src_a), .id_src_b(id_src_b),
      .id_use_a(id_use_a), .id_use_b(id_use_b), .id_src_vec(id_src_vec),
      .ex_valid(ex_valid), .ex_pc_write_en(ex_pc_write_en), .ex_zero(ex_zero),
      .ex_reg_write_sc(ex_reg_write_sc), .ex_reg_write_vec(ex_reg_write_vec),
      .ex_reg_to_write(ex_reg_to_write), .ex_write_reg_from(ex_write_reg_from),
      .ex_vec_mem(ex_vec_mem), .mem_ready(mem_ready),
      .pc_stall(pc_stall), .ifid_stall(ifid_stall), .ifid_flush(ifid_flush),
      .idex_flush(idex_flush), .exmem_stall(exmem_stall), .pc_sel(pc_sel),
      .mem_req(mem_req), .beat_idx(beat_idx), .vmem_busy(vmem_busy),
      .stall_cycles(stall_cycles)
   );

   pipeline_hazard_ctrl #(.VEC_BEATS(c_VB), .CNT_W(4)) dut4 (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_src_a(id_src_a), .id_src_b(id_src_b),
      .id_use_a(id_use_a), .id_use_b(id_use_b), .id_src_vec(id_src_vec),
      .ex_valid(ex_valid), .ex_pc_write_en(ex_pc_write_en), .ex_zero(ex_zero),
      .ex_reg_write_sc(ex_reg_write_sc), .ex_reg_write_vec(ex_reg_write_vec),
      .ex_reg_to_write(ex_reg_to_write), .ex_write_reg_from(ex_write_reg_from),
      .ex_vec_mem(ex_vec_mem), .mem_ready(mem_ready),
      .pc_stall(pc_stall4), .ifid_stall(ifid_stall4), .ifid_flush(ifid_flush4),
      .idex_flush(idex_flush4), .exmem_stall(exmem_stall4), .pc_sel(pc_sel4),
      .mem_req(mem_req4), .beat_idx(beat_idx4), .vmem_busy(vmem_busy4),
      .stall_cycles(stall_cycles4)
   );

   // Bit order: pc_stall ifid_stall ifid_flush idex_flush exmem_stall pc_sel mem_req vmem_busy
   logic [7:0] obs, obs4;
   assign obs  = {pc_stall, ifid_stall, ifid_flush, idex_flush, exmem_stall, pc_sel, mem_req, vmem_busy};
   assign obs4 = {pc_stall4, ifid_stall4, ifid_flush4, idex_flush4, exmem_stall4, pc_sel4, mem_req4, vmem_busy4};

   localparam logic [7:0] c_NONE   = 8'b0000_0000;
   localparam logic [7:0] c_BRANCH = 8'b0011_0100;
   localparam logic [7:0] c_LDUSE  = 8'b1101_0000;
   localparam logic [7:0] c_VENTRY = 8'b1100_1000;
   localparam logic [7:0] c_VMEM   = 8'b1100_1011;

   // ------------------------------------------------------------------------
   // Behavioural reference model: "beats left" bookkeeping plus counters.
   // ------------------------------------------------------------------------
   bit         mInVmem, mDone;
   int         mBeat, mCnt, mCnt4;
   logic [7:0] expCtl;
   bit         mTake, mVec, mLd;

   always_comb begin
      mTake = ex_valid && (ex_pc_write_en == 3'b100
                        || (ex_pc_write_en == 3'b010 && ex_zero)
                        || (ex_pc_write_en == 3'b001 && !ex_zero));
      mVec  = ex_valid && ex_vec_mem;
      mLd   = ex_valid && !ex_vec_mem && ex_write_reg_from == 2'd0 && id_valid
           && ((id_src_vec ? ex_reg_write_vec : ex_reg_write_sc) == 1'b1)
           && ((id_use_a && id_src_a == ex_reg_to_write) || (id_use_b && id_src_b == ex_reg_to_write));
      expCtl = c_NONE;
      if (rst === 1'b1) begin
         if (mInVmem)               expCtl = c_VMEM;
         else if (mVec && !mDone)   expCtl = c_VENTRY;
         else if (mTake && !mVec)   expCtl = c_BRANCH;
         else if (mLd)              expCtl = c_LDUSE;
      end
   end

   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         mInVmem <= 1'b0; mDone <= 1'b0; mBeat <= 0; mCnt <= 0; mCnt4 <= 0;
      end else begin
         if (expCtl[7]) begin
            mCnt  <= (mCnt  < 65535) ? mCnt + 1  : mCnt;
            mCnt4 <= (mCnt4 < 15)    ? mCnt4 + 1 : mCnt4;
         end
         if (mInVmem) begin
            if (mem_ready) begin
               if (mBeat == c_VB - 1) begin
                  mInVmem <= 1'b0; mBeat <= 0; mDone <= 1'b1;
               end else begin
                  mBeat <= mBeat + 1;
               end
            end
         end else begin
            if (!expCtl[7]) mDone <= 1'b0;
            if (mVec && !mDone) begin mInVmem <= 1'b1; mBeat <= 0; end
         end
      end
   end

   // ------------------------------------------------------------------------
   task automatic clearIn();
      id_valid = 0; id_src_a = 0; id_src_b = 0; id_use_a = 0; id_use_b = 0; id_src_vec = 0;
      ex_valid = 0; ex_pc_write_en = 0; ex_zero = 0; ex_reg_write_sc = 0; ex_reg_write_vec = 0;
      ex_reg_to_write = 0; ex_write_reg_from = 2'd1; ex_vec_mem = 0; mem_ready = 0;
   endtask

   task automatic pulseReset();
      @(negedge clk); rst = 1'b0;
      @(negedge clk); rst = 1'b1; clearIn();
   endtask

   task automatic test_reset();
      clearIn();
      #1 rst = 1'b0;
      @(negedge clk);
      ex_valid = 1; ex_vec_mem = 1; ex_pc_write_en = 3'b100; id_valid = 1;
      #2;
      nAssert++;
      if (obs !== c_NONE || beat_idx !== '0 || stall_cycles !== 16'd0) begin
         nFail++;
         $display("FAIL reset_hold: ctl=%b beat=%0d cnt=%0d required ctl=00000000 beat=0 cnt=0", obs, beat_idx, stall_cycles);
      end
      @(negedge clk); clearIn(); rst = 1'b1;
      #2;
      nAssert++;
      if (obs !== c_NONE || obs !== expCtl) begin
         nFail++; $display("FAIL reset_release: ctl=%b required %b", obs, c_NONE);
      end
   endtask

   task automatic test_reset_mid_vmem();
      @(negedge clk); clearIn(); ex_valid = 1; ex_vec_mem = 1; mem_ready = 1;
      repeat (3) @(negedge clk);
      #1;
      nAssert++;
      if (beat_idx !== 2'd2 || mem_req !== 1'b1) begin
         nFail++; $display("FAIL mid_vmem_setup: beat=%0d mem_req=%b required beat=2 mem_req=1", beat_idx, mem_req);
      end
      rst = 1'b0;
      #1;
      nAssert++;
      if (obs !== c_NONE || beat_idx !== '0 || stall_cycles !== 16'd0) begin
         nFail++;
         $display("FAIL mid_vmem_reset: ctl=%b beat=%0d cnt=%0d required 00000000/0/0", obs, beat_idx, stall_cycles);
      end
      @(negedge clk); rst = 1'b1; clearIn(); mem_ready = 1;
      repeat (2) begin
         #2;
         nAssert++;
         if (obs !== c_NONE || beat_idx !== '0) begin
            nFail++; $display("FAIL mid_vmem_after: ctl=%b beat=%0d required 00000000/0", obs, beat_idx);
         end
         @(negedge clk);
      end
   endtask

   task automatic test_branch();
      logic [2:0] pcTab    [7] = '{3'b010, 3'b010, 3'b001, 3'b001, 3'b100, 3'b000, 3'b100};
      logic       zTab     [7] = '{1'b1,   1'b0,   1'b0,   1'b1,   1'b0,   1'b1,   1'b1};
      logic       vTab     [7] = '{1'b1,   1'b1,   1'b1,   1'b1,   1'b1,   1'b1,   1'b0};
      logic       takenTab [7] = '{1'b1,   1'b0,   1'b1,   1'b0,   1'b1,   1'b0,   1'b0};
      for (int i = 0; i < 7; i++) begin
         @(negedge clk); clearIn();
         ex_valid = vTab[i]; ex_pc_write_en = pcTab[i]; ex_zero = zTab[i];
         #2;
         nAssert++;
         if (obs !== (takenTab[i] ? c_BRANCH : c_NONE)) begin
            nFail++; $display("FAIL branch_%0d: ctl=%b required %b", i, obs, takenTab[i] ? c_BRANCH : c_NONE);
         end
      end
      @(negedge clk); clearIn();
      #2;
      nAssert++;
      if (obs !== c_NONE) begin
         nFail++; $display("FAIL branch_oneshot: ctl=%b required 00000000", obs);
      end
   endtask

   task automatic test_load_use();
      // case: 0 scalar hit on A, 1 scalar load vs vector reader, 2 vector hit on B,
      //       3 ALU producer, 4 id_valid low
      logic stallTab [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
      logic [15:0] cnt0;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk); clearIn();
         ex_valid = 1; ex_write_reg_from = 2'd0; ex_reg_to_write = 4'd5; id_valid = 1;
         case (i)
            0: begin ex_reg_write_sc = 1; id_src_a = 5; id_use_a = 1; id_src_b = 2; id_use_b = 1; end
            1: begin ex_reg_write_sc = 1; id_src_a = 5; id_use_a = 1; id_src_vec = 1; end
            2: begin ex_reg_write_vec = 1; id_src_vec = 1; id_src_a = 3; id_use_a = 1; id_src_b = 5; id_use_b = 1; end
            3: begin ex_reg_write_sc = 1; ex_write_reg_from = 2'd1; id_src_a = 5; id_use_a = 1; end
            default: begin ex_reg_write_sc = 1; id_src_a = 5; id_use_a = 1; id_valid = 0; end
         endcase
         #2;
         cnt0 = stall_cycles;
         nAssert++;
         if (obs !== (stallTab[i] ? c_LDUSE : c_NONE)) begin
            nFail++; $display("FAIL load_use_%0d: ctl=%b required %b", i, obs, stallTab[i] ? c_LDUSE : c_NONE);
         end
         @(negedge clk); ex_valid = 0;
         #2;
         nAssert++;
         if (obs !== c_NONE || stall_cycles !== cnt0 + (stallTab[i] ? 16'd1 : 16'd0)) begin
            nFail++;
            $display("FAIL load_use_resume_%0d: ctl=%b cnt=%0d required 00000000 cnt=%0d", i, obs, stall_cycles, cnt0 + (stallTab[i] ? 16'd1 : 16'd0));
         end
      end
   endtask

   task automatic test_lopix();
      int nStall = 0;
      int beats[$];
      bit exited = 0;
      pulseReset();
      @(negedge clk); ex_valid = 1; ex_vec_mem = 1; mem_ready = 1;
      for (int c = 0; c < 12 && !exited; c++) begin
         #2;
         nAssert++;
         if (obs !== expCtl) begin
            nFail++; $display("FAIL lopix_cycle_%0d: ctl=%b required %b", c, obs, expCtl);
         end
         if (mem_req === 1'b1) beats.push_back(int'(beat_idx));
         if (pc_stall === 1'b1) nStall++;
         else if (nStall > 0) exited = 1;
         if (!exited) @(negedge clk);
      end
      nAssert++;
      if (!exited || nStall != 5 || stall_cycles !== 16'd5) begin
         nFail++; $display("FAIL lopix_length: exited=%0d stalls=%0d cnt=%0d required 1/5/5", exited, nStall, stall_cycles);
      end
      nAssert++;
      if (beats.size() != 4 || beats[0] != 0 || beats[1] != 1 || beats[2] != 2 || beats[3] != 3) begin
         nFail++; $display("FAIL lopix_beats: got %p required 0,1,2,3", beats);
      end
      nAssert++;
      if (obs !== c_NONE) begin
         nFail++; $display("FAIL lopix_reentry: ctl=%b required 00000000", obs);
      end
      @(negedge clk); clearIn();
   endtask

   task automatic test_svpix_gap();
      int expBeat [8] = '{0, 0, 1, 1, 1, 1, 2, 3};
      int nStall = 0;
      pulseReset();
      @(negedge clk); ex_valid = 1; ex_vec_mem = 1;
      for (int c = 0; c < 10; c++) begin
         mem_ready = !(c >= 2 && c <= 4);
         if (c == 9) begin ex_valid = 0; ex_vec_mem = 0; end
         #2;
         if (pc_stall === 1'b1) nStall++;
         nAssert++;
         if (pc_stall !== (c <= 7) || mem_req !== (c >= 1 && c <= 7)
             || (c >= 1 && c <= 7 && int'(beat_idx) != expBeat[c])) begin
            nFail++;
            $display("FAIL svpix_cycle_%0d: stall=%b req=%b beat=%0d required stall=%b req=%b beat=%0d",
                     c, pc_stall, mem_req, beat_idx, (c <= 7), (c >= 1 && c <= 7), (c < 8) ? expBeat[c] : 0);
         end
         @(negedge clk);
      end
      nAssert++;
      if (nStall != 8 || stall_cycles !== 16'd8) begin
         nFail++; $display("FAIL svpix_total: stalls=%0d cnt=%0d required 8/8", nStall, stall_cycles);
      end
      clearIn();
   endtask

   task automatic test_take_with_ld_use();
      logic [15:0] cnt0;
      @(negedge clk); clearIn();
      ex_valid = 1; ex_pc_write_en = 3'b100; ex_write_reg_from = 2'd0; ex_reg_write_sc = 1;
      ex_reg_to_write = 4'd5; id_valid = 1; id_src_a = 5; id_use_a = 1;
      #2;
      cnt0 = stall_cycles;
      nAssert++;
      if (obs !== c_BRANCH) begin
         nFail++; $display("FAIL take_ld_use: ctl=%b required %b", obs, c_BRANCH);
      end
      @(negedge clk); clearIn();
      #2;
      nAssert++;
      if (obs !== c_NONE || stall_cycles !== cnt0) begin
         nFail++; $display("FAIL take_ld_use_cnt: ctl=%b cnt=%0d required 00000000 cnt=%0d", obs, stall_cycles, cnt0);
      end
   endtask

   task automatic test_saturation();
      pulseReset();
      @(negedge clk); ex_valid = 1; ex_vec_mem = 1; mem_ready = 0;
      repeat (20) @(negedge clk);
      #2;
      nAssert++;
      if (stall_cycles4 !== 4'd15 || stall_cycles !== 16'd20) begin
         nFail++; $display("FAIL saturate: cnt4=%0d cnt16=%0d required 15/20", stall_cycles4, stall_cycles);
      end
      mem_ready = 1;
      repeat (4) @(negedge clk);
      #2;
      nAssert++;
      if (stall_cycles4 !== 4'd15 || stall_cycles !== 16'd24 || obs !== c_NONE || obs4 !== c_NONE) begin
         nFail++;
         $display("FAIL saturate_exit: cnt4=%0d cnt16=%0d ctl=%b required 15/24/00000000", stall_cycles4, stall_cycles, obs);
      end
      @(negedge clk); clearIn();
   endtask

   task automatic test_random();
      for (int c = 0; c < 1500; c++) begin
         @(negedge clk);
         rst               = ($urandom_range(0, 149) != 0);
         id_valid          = $urandom_range(0, 3) != 0;
         id_src_a          = 4'($urandom_range(0, 3));
         id_src_b          = 4'($urandom_range(0, 3));
         id_use_a          = 1'($urandom);
         id_use_b          = 1'($urandom);
         id_src_vec        = 1'($urandom);
         ex_valid          = $urandom_range(0, 3) != 0;
         ex_pc_write_en    = ($urandom_range(0, 2) == 0) ? 3'(1 << $urandom_range(0, 2)) : 3'b000;
         ex_zero           = 1'($urandom);
         ex_reg_write_sc   = 1'($urandom);
         ex_reg_write_vec  = 1'($urandom);
         ex_reg_to_write   = 4'($urandom_range(0, 3));
         ex_write_reg_from = 2'($urandom_range(0, 2));
         ex_vec_mem        = ($urandom_range(0, 7) == 0);
         mem_ready         = ($urandom_range(0, 3) != 0);
         #2;
         nAssert++;
         if (obs !== expCtl || obs4 !== expCtl || beat_idx !== c_BW'(mBeat)
             || stall_cycles !== 16'(mCnt) || stall_cycles4 !== 4'(mCnt4)) begin
            nFail++;
            if (nFail < 20)
               $display("FAIL random_%0d: ctl=%b beat=%0d cnt=%0d cnt4=%0d required ctl=%b beat=%0d cnt=%0d cnt4=%0d",
                        c, obs, beat_idx, stall_cycles, stall_cycles4, expCtl, mBeat, mCnt, mCnt4);
         end
      end
      @(negedge clk); rst = 1'b1; clearIn();
   endtask

   initial begin
      test_reset();
      test_reset_mid_vmem();
      test_branch();
      test_load_use();
      test_lopix();
      test_svpix_gap();
      test_take_with_ld_use();
      test_saturation();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central pipeline controller for the SIMD core. Consumes the control word that the decode stage produced and that is now held in ID/EX, plus the source-register info of the instruction currently in decode.
- Generates the stall, flush and PC-select signals for all pipeline registers.
- Handles three cases: taken branches (jmp/je/jne), load-use hazards, and multi-beat vector memory operations (lopix/svpix).
- A multi-beat vector memory operation freezes the pipeline until all beats are accepted by memory.

Parameters:
- VEC_BEATS, default 4: memory beats per lopix/svpix transfer (≥2).
- CNT_W, default 16: width of the stall-cycle performance counter.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- id_valid  in  1  decode stage holds a valid instruction
- id_src_a  in  4  decode source register A
- id_src_b  in  4  decode source register B
- id_use_a  in  1  source A is read
- id_use_b  in  1  source B is read
- id_src_vec  in  1  sources are vector registers (0 = scalar)
- ex_valid  in  1  ID/EX holds a valid instruction
- ex_pc_write_en  in  3  100 jmp, 010 je, 001 jne, 000 none
- ex_zero  in  1  Z flag result for the branch in EX
- ex_reg_write_sc  in  1  EX instruction writes a scalar register
- ex_reg_write_vec  in  1  EX instruction writes a vector register
- ex_reg_to_write  in  4  EX destination register
- ex_write_reg_from  in  2  0 = memory, 1 = ALU, 2 = immediate
- ex_vec_mem  in  1  EX instruction is lopix/svpix
- mem_ready  in  1  memory accepts the current vector beat
- pc_stall  out  1  hold PC
- ifid_stall  out  1  hold IF/ID
- ifid_flush  out  1  clear IF/ID to a NOP
- idex_flush  out  1  insert a bubble into ID/EX
- exmem_stall  out  1  hold ID/EX and EX/MEM
- pc_sel  out  1  1 = load the branch target into PC
- mem_req  out  1  vector beat request
- beat_idx  out  clog2(VEC_BEATS)  current beat number
- vmem_busy  out  1  FSM is in the VMEM state
- stall_cycles  out  CNT_W  saturating count of cycles with pc_stall=1

Behaviour:
- Reset (rst=0, asynchronous):
  - State = RUN; beat_idx = 0; stall_cycles = 0.
  - All outputs are 0 while reset is asserted.
  - Reset during VMEM aborts the transfer; no further mem_req is issued.
- Derived conditions:
  - take = ex_valid & (pc[2] | (pc[1] & ex_zero) | (pc[0] & ~ex_zero)), where pc = ex_pc_write_en.
  - ld_use = ex_valid & ~ex_vec_mem & (ex_write_reg_from==0) & ((ex_reg_write_sc & ~id_src_vec) | (ex_reg_write_vec & id_src_vec)) & id_valid & ((id_use_a & id_src_a==ex_reg_to_write) | (id_use_b & id_src_b==ex_reg_to_write)).
  - vstart = ex_valid & ex_vec_mem.
- State RUN (all outputs combinational from the current inputs):
  - Priority is vstart > take > ld_use.
  - vstart:
    - Assert pc_stall, ifid_stall and exmem_stall in the same cycle.
    - Next state = VMEM, beat_idx = 0.
    - mem_req is not yet asserted in this cycle.
  - take:
    - Assert pc_sel, ifid_flush and idex_flush for exactly that cycle.
    - No stall is asserted.
    - A coincident ld_use is ignored, because the dependent instruction is flushed.
  - ld_use:
    - Assert pc_stall, ifid_stall and idex_flush for one cycle.
    - Next cycle the load has moved on, ld_use drops and the pipeline resumes. Latency = exactly one bubble.
  - None of the above: all control outputs are 0.
- State VMEM:
  - vmem_busy=1, mem_req=1, and pc_stall, ifid_stall, exmem_stall held at 1.
  - pc_sel and both flushes are 0.
  - Beat handshake: a beat completes on a rising edge with mem_req & mem_ready. Then beat_idx increments.
  - With mem_ready=0, beat_idx holds and the stalls persist indefinitely.
  - When the beat with beat_idx==VEC_BEATS-1 completes: next state = RUN, beat_idx wraps to 0, and all stalls drop in the next cycle.
  - Minimum occupancy is 1 + VEC_BEATS stall cycles (entry cycle plus VEC_BEATS beat cycles).
  - ex_* inputs are ignored in VMEM. ID/EX is frozen, so ex_vec_mem stays high.
  - Re-entry is prevented: the first RUN cycle after completion does not re-evaluate vstart for the same instruction. An internal done flag is set on exit and cleared on the first non-stalled advance.
- stall_cycles:
  - Increments on every rising edge where pc_stall=1.
  - Saturates at 2^CNT_W-1; no wrap.
- Branch and vector memory operations are mutually exclusive per instruction. If both are presented, vstart wins and the branch is ignored.

Test Plan:
1. Reset mid-VMEM (VEC_BEATS=4, beat_idx=2, rst=0 for 1 cycle) -> state RUN, beat_idx=0, mem_req=0, stall_cycles=0, all stalls 0.
2. ex_pc_write_en=3'b010 with ex_zero=1, ex_valid=1 -> pc_sel=1, ifid_flush=1, idex_flush=1 for 1 cycle. Repeat with ex_zero=0 -> all 0. Repeat with jne and ex_zero=0 -> taken.
3. lmem in EX (write_reg_from=0, reg_write_sc=1, dest=5) with decode id_src_a=5, id_use_a=1, id_src_vec=0 -> one cycle of pc_stall/ifid_stall/idex_flush, then 0. Repeat with id_src_vec=1 -> no stall.
4. lopix in EX with mem_ready=1 constantly -> stalls high for exactly 5 cycles; beat_idx 0,1,2,3; stall_cycles=5; no re-entry afterwards.
5. svpix in EX with mem_ready low for 3 cycles on beat 1 -> beat_idx holds at 1 for 3 cycles; total stall = 8 cycles.
6. Taken jmp coincident with ld_use -> flush only, no stall, stall_cycles unchanged. CNT_W=4 with 20 stall cycles -> stall_cycles saturates at 15.
